// File: rtl/mnist_pixel_fetch.sv
// mnist_pixel_fetch: sequential reader for one 28x28 image held in a 1-cycle-latency ROM.
// Streams pixels on a valid/ready port with row-end and image-end markers. A 2-entry FIFO
// absorbs the ROM latency and downstream stalls.
module mnist_pixel_fetch #(
    parameter int IMG_PIXELS = 784,
    parameter int ROW_LEN    = 28,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rom_ren,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_eol,
    output logic              o_pix_last
);

    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(IMG_PIXELS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_out_idx;
    logic [COL_W-1:0]    r_col;
    logic                r_inflight;
    logic [DATA_W-1:0]   r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_abort;
    logic [2:0]          w_occ;
    logic                w_rom_ren;

    // Read issue: only request a byte when a FIFO slot is guaranteed for it.
    always_comb begin
        w_valid   = (r_count != 2'd0);
        w_pop     = w_valid && i_pix_ready;
        w_abort   = i_abort && (r_state == StFetch);
        w_push    = r_inflight && !w_abort;
        // Pop implies count >= 1, so this never underflows.
        w_occ     = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        w_rom_ren = (r_state == StFetch) && (r_rd_addr < ADDR_END) && !i_abort &&
                    (w_occ < 3'd2);
    end

    // Control FSM with read address, output index and column counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_addr <= '0;
            r_out_idx <= '0;
            r_col     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state   <= StFetch;
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                        r_out_idx <= '0;
                        r_col     <= '0;
                    end
                end
                StFetch: begin
                    if (i_abort) begin
                        r_state   <= StIdle;
                        r_busy    <= 1'b0;
                        r_rd_addr <= '0;
                        r_out_idx <= '0;
                        r_col     <= '0;
                    end else begin
                        if (w_rom_ren) begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                        if (w_pop) begin
                            r_out_idx <= r_out_idx + ADDR_W'(1);
                            r_col     <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
                            if (r_out_idx == IDX_LAST) begin
                                r_state <= StDone;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // 2-entry FIFO plus in-flight flag; abort discards both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else if (w_abort) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_rom_ren;
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_rom_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Output drive: markers are qualified by valid so idle outputs read as zero.
    always_comb begin
        o_busy      = r_busy;
        o_done      = r_done;
        o_rom_ren   = w_rom_ren;
        o_rom_addr  = r_rd_addr;
        o_pix_valid = w_valid;
        o_pix_data  = r_mem[r_rd_ptr];
        o_pix_eol   = w_valid && (r_col == COL_LAST);
        o_pix_last  = w_valid && (r_out_idx == IDX_LAST);
    end

endmodule

// File: tb/tb_mnist_pixel_fetch.sv
// Scoreboard bench for mnist_pixel_fetch: stimulus queues the expected pixel stream,
// a negedge monitor pops and compares on each accepted pixel.
module tb_mnist_pixel_fetch;

    localparam int NPIX = 784;
    localparam int ROWL = 28;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       rom_ren;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_eol;
    logic       pix_last;

    mnist_pixel_fetch #(
        .IMG_PIXELS (NPIX),
        .ROW_LEN    (ROWL),
        .ADDR_W     (10),
        .DATA_W     (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .o_busy      (busy),
        .o_done      (done),
        .o_rom_ren   (rom_ren),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_pix_valid (pix_valid),
        .i_pix_ready (pix_ready),
        .o_pix_data  (pix_data),
        .o_pix_eol   (pix_eol),
        .o_pix_last  (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: rom[i] = i % 28, one cycle read latency.
    initial rom_data = 8'd0;
    always @(posedge clk) if (rom_ren) rom_data <= 8'(int'(rom_addr) % ROWL);

    typedef struct {
        logic [7:0] data;
        logic       eol;
        logic       last;
        int         idx;
    } pix_t;

    pix_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    int   ren_total = 0, acc_total = 0, done_total = 0, eol_total = 0;
    int   first_cyc = 0, last_cyc = 0;
    int   outstanding = 0;
    bit   prev_stall = 0, last_prev = 0;
    logic [7:0] prev_data;
    logic       prev_eol, prev_last;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected image from the rule pixel k = k mod 28, eol at column 27, last at k=783.
    task automatic push_image();
        pix_t p;
        for (int k = 0; k < NPIX; k++) begin
            p.data = 8'(k % ROWL);
            p.eol  = ((k % ROWL) == ROWL - 1);
            p.last = (k == NPIX - 1);
            p.idx  = k;
            sb.push_back(p);
        end
    endtask

    // Monitor: compares accepted pixels, stall stability, done timing, storage bound.
    always @(negedge clk) begin
        pix_t e;
        int   nxt;
        if (!rst_n || (abort && busy)) begin
            sb.delete();
            outstanding = 0;
            prev_stall  = 0;
            last_prev   = 0;
        end else begin
            if (done) done_total++;
            if (done || last_prev) chk("done_after_last", int'(done), int'(last_prev));
            last_prev = 0;
            if (prev_stall) begin
                chk("stall_valid", int'(pix_valid), 1);
                chk("stall_data", int'(pix_data), int'(prev_data));
                chk("stall_flags", int'({pix_eol, pix_last}), int'({prev_eol, prev_last}));
            end
            nxt = outstanding + int'(rom_ren) - int'(pix_valid && pix_ready);
            if (rom_ren) begin
                ren_total++;
                chk("storage_le2", int'(nxt <= 2), 1);
            end
            outstanding = nxt;
            if (pix_valid && pix_ready) begin
                acc_total++;
                if (pix_eol) eol_total++;
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", int'(pix_data), -1);
                end else begin
                    e = sb.pop_front();
                    chk("pix_data", int'(pix_data), int'(e.data));
                    chk("pix_eol", int'(pix_eol), int'(e.eol));
                    chk("pix_last", int'(pix_last), int'(e.last));
                    if (e.idx == 0) first_cyc = cyc;
                    if (e.idx == NPIX - 1) last_cyc = cyc;
                    if (pix_last) last_prev = 1;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_eol   = pix_eol;
            prev_last  = pix_last;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Waits for done; optionally randomises pix_ready each cycle.
    task automatic run_until_done(input int bound, input bit rnd);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_within_bound", int'(seen), 1);
        pix_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int d0, a0, r0, e0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ren", int'(rom_ren), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_data", int'(pix_data), 0);
        chk("rst_marks", int'({pix_eol, pix_last}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle_cycles(2);

        // 1: full stream, ready high.
        d0 = done_total; e0 = eol_total;
        push_image();
        pulse_start();
        chk("t1_busy", int'(busy), 1);
        run_until_done(2000, 0);
        idle_cycles(2);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_done_count", done_total - d0, 1);
        chk("t1_eol_count", eol_total - e0, 28);
        chk("t1_no_bubbles", last_cyc - first_cyc, NPIX - 1);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: random backpressure.
        d0 = done_total; a0 = acc_total;
        push_image();
        pulse_start();
        run_until_done(6000, 1);
        idle_cycles(2);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_pixels", acc_total - a0, NPIX);
        chk("t2_done_count", done_total - d0, 1);

        // 3: hold ready low for 20 cycles after start.
        r0 = ren_total; a0 = acc_total;
        pix_ready = 1'b0;
        push_image();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; pix_ready = 1'b0;
        idle_cycles(19);
        chk("t3_ren_count", ren_total - r0, 2);
        chk("t3_valid", int'(pix_valid), 1);
        chk("t3_data", int'(pix_data), 0);
        chk("t3_none_accepted", acc_total - a0, 0);
        pix_ready = 1'b1;
        run_until_done(2000, 0);
        idle_cycles(2);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: abort after 100 pixels, then restart from pixel 0.
        a0 = acc_total; d0 = done_total;
        push_image();
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (acc_total - a0 >= 100) break;
            @(posedge clk); #1;
        end
        chk("t4_reached_100", acc_total - a0, 100);
        pix_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t4_valid_after_abort", int'(pix_valid), 0);
        chk("t4_busy_after_abort", int'(busy), 0);
        idle_cycles(5);
        chk("t4_no_done", done_total - d0, 0);
        chk("t4_still_idle", int'(busy), 0);
        chk("t4_accepted", acc_total - a0, 100);
        pix_ready = 1'b1;
        push_image();
        pulse_start();
        run_until_done(2000, 0);
        idle_cycles(2);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_restart_done", done_total - d0, 1);

        // 5: start pulses while busy and during DONE are ignored.
        a0 = acc_total; d0 = done_total;
        push_image();
        pulse_start();
        idle_cycles(50);
        pulse_start();
        run_until_done(2000, 0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idle_cycles(10);
        chk("t5_busy", int'(busy), 0);
        chk("t5_pixels", acc_total - a0, NPIX);
        chk("t5_done_count", done_total - d0, 1);
        chk("t5_sb_empty", sb.size(), 0);

        // 6: asynchronous reset mid-fetch.
        push_image();
        pulse_start();
        idle_cycles(60);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(pix_valid), 0);
        chk("t6_ren", int'(rom_ren), 0);
        chk("t6_addr", int'(rom_addr), 0);
        chk("t6_data", int'(pix_data), 0);
        chk("t6_marks", int'({pix_eol, pix_last}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle_cycles(5);
        chk("t6_idle_busy", int'(busy), 0);
        chk("t6_idle_valid", int'(pix_valid), 0);
        a0 = acc_total; d0 = done_total;
        push_image();
        pulse_start();
        run_until_done(2000, 0);
        idle_cycles(2);
        chk("t6_pixels", acc_total - a0, NPIX);
        chk("t6_done_count", done_total - d0, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
